// File: rtl/priority_decoder.sv
// priority_decoder
//   Registered priority encoder: reports the index of the highest-numbered
//   set bit of din, plus a valid flag, one clock after din is sampled.
//
//   Optional feature macro: PRIORITY_DECODER_ONEHOT_ERR_EN
//     When defined, adds output err, which flags multi-hot requests.
//
// Parameters
//   WIDTH  number of request bits (2..64)
//   OUT_W  derived index width, $clog2(WIDTH); not overridable
//
// Ports
//   clk    in   system clock, rising-edge
//   rst_n  in   synchronous active-low reset
//   din    in   [WIDTH-1:0] request vector
//   out    out  [OUT_W-1:0] registered index of highest set bit (0 if none)
//   valid  out  registered, 1 when any din bit was set
//   err    out  registered, 1 when more than one din bit was set (macro only)
module priority_decoder #(
  parameter int WIDTH = 4,
  localparam int OUT_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] din,
  output logic [OUT_W-1:0] out,
  output logic             valid
`ifdef PRIORITY_DECODER_ONEHOT_ERR_EN
  ,
  output logic             err
`endif
);

  logic [OUT_W-1:0] w_idx;
  logic             w_any;
  logic [OUT_W-1:0] r_out;
  logic             r_valid;

  // Ascending scan: later (higher) set bits overwrite earlier ones, so the
  // most significant set bit wins. Only indices 0..WIDTH-1 can be produced.
  always_comb begin
    w_idx = '0;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      if (din[i]) begin
        w_idx = OUT_W'(i);
      end
    end
  end

  assign w_any = |din;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_out   <= '0;
      r_valid <= 1'b0;
    end else begin
      r_out   <= w_idx;
      r_valid <= w_any;
    end
  end

  assign out   = r_out;
  assign valid = r_valid;

`ifdef PRIORITY_DECODER_ONEHOT_ERR_EN
  logic w_multi;
  logic r_err;

  // Clearing the lowest set bit leaves something only if 2+ bits were set.
  assign w_multi = |(din & (din - WIDTH'(1)));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_err <= 1'b0;
    end else begin
      r_err <= w_multi;
    end
  end

  assign err = r_err;
`endif

endmodule

// File: tb/tb_priority_decoder.sv
module tb_priority_decoder;

  localparam int WIDTH = 4;
  localparam int OUT_W = $clog2(WIDTH);

  logic             clk;
  logic             rst_n;
  logic [WIDTH-1:0] din;
  logic [OUT_W-1:0] out;
  logic             valid;
`ifdef PRIORITY_DECODER_ONEHOT_ERR_EN
  logic             err;
`endif

  int vectors;
  int miscompares;

  priority_decoder #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .din   (din),
    .out   (out),
    .valid (valid)
`ifdef PRIORITY_DECODER_ONEHOT_ERR_EN
    ,
    .err   (err)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: highest set bit index of a positive value v is
  // ceil(log2(v+1)) - 1; zero maps to index 0 with valid low.
  function automatic logic [OUT_W-1:0] m_idx(input logic [WIDTH-1:0] d);
    int v;
    v = int'(d);
    if (v == 0) return '0;
    return OUT_W'($clog2(v + 1) - 1);
  endfunction

  function automatic logic m_valid(input logic [WIDTH-1:0] d);
    return d != '0;
  endfunction

  function automatic logic m_err(input logic [WIDTH-1:0] d);
    return $countones(d) > 1;
  endfunction

  // Apply inputs away from the active edge, then sample just after it.
  task automatic step(input logic [WIDTH-1:0] d, input logic r);
    @(negedge clk);
    din   = d;
    rst_n = r;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    for (int n = 0; n < 2; n++) begin
      step(4'b1111, 1'b0);
      vectors++;
      if (out !== '0 || valid !== 1'b0) begin
        miscompares++;
        $display("FAIL reset_hold: out=%b valid=%b expected out=00 valid=0", out, valid);
      end
`ifdef PRIORITY_DECODER_ONEHOT_ERR_EN
      vectors++;
      if (err !== 1'b0) begin
        miscompares++;
        $display("FAIL reset_err: err=%b expected 0", err);
      end
`endif
    end
    step(4'b1111, 1'b1);
    vectors++;
    if (out !== 2'd3 || valid !== 1'b1) begin
      miscompares++;
      $display("FAIL reset_release: out=%b valid=%b expected out=11 valid=1", out, valid);
    end
  endtask

  task automatic test_onehot_walk();
    for (int i = 0; i < WIDTH; i++) begin
      logic [WIDTH-1:0] d;
      d = '0;
      d[i] = 1'b1;
      step(d, 1'b1);
      vectors++;
      if (out !== OUT_W'(i) || valid !== 1'b1) begin
        miscompares++;
        $display("FAIL onehot_walk din=%b: out=%b valid=%b expected out=%0d valid=1", d, out, valid, i);
      end
`ifdef PRIORITY_DECODER_ONEHOT_ERR_EN
      vectors++;
      if (err !== 1'b0) begin
        miscompares++;
        $display("FAIL onehot_err din=%b: err=%b expected 0", d, err);
      end
`endif
    end
  endtask

  task automatic test_empty();
    step(4'b0000, 1'b1);
    vectors++;
    if (out !== 2'b00 || valid !== 1'b0) begin
      miscompares++;
      $display("FAIL empty: out=%b valid=%b expected out=00 valid=0", out, valid);
    end
`ifdef PRIORITY_DECODER_ONEHOT_ERR_EN
    vectors++;
    if (err !== 1'b0) begin
      miscompares++;
      $display("FAIL empty_err: err=%b expected 0", err);
    end
`endif
  endtask

  task automatic test_multihot();
    logic [WIDTH-1:0] pats [4];
    logic [OUT_W-1:0] idx  [4];
    logic             mh   [4];
    pats = '{4'b0110, 4'b1111, 4'b0011, 4'b0100};
    idx  = '{2'd2,    2'd3,    2'd1,    2'd2};
    mh   = '{1'b1,    1'b1,    1'b1,    1'b0};
    for (int k = 0; k < 4; k++) begin
      step(pats[k], 1'b1);
      vectors++;
      if (out !== idx[k] || valid !== 1'b1) begin
        miscompares++;
        $display("FAIL multihot din=%b: out=%b valid=%b expected out=%b valid=1", pats[k], out, valid, idx[k]);
      end
`ifdef PRIORITY_DECODER_ONEHOT_ERR_EN
      vectors++;
      if (err !== mh[k]) begin
        miscompares++;
        $display("FAIL multihot_err din=%b: err=%b expected %b", pats[k], err, mh[k]);
      end
`else
      if (mh[k] === 1'bx) $display("unexpected pattern table entry");
`endif
    end
  endtask

  task automatic test_latency();
    step(4'b0001, 1'b1);
    #2;
    din = 4'b1000;  // mid-cycle change; outputs must hold
    #1;
    vectors++;
    if (out !== 2'd0 || valid !== 1'b1) begin
      miscompares++;
      $display("FAIL latency_hold: out=%b valid=%b expected out=00 valid=1", out, valid);
    end
    @(posedge clk);
    #1;
    vectors++;
    if (out !== 2'd3 || valid !== 1'b1) begin
      miscompares++;
      $display("FAIL latency_update: out=%b valid=%b expected out=11 valid=1", out, valid);
    end
  endtask

  task automatic test_reset_midstream();
    step(4'b1000, 1'b1);
    step(4'b1000, 1'b0);
    vectors++;
    if (out !== 2'd0 || valid !== 1'b0) begin
      miscompares++;
      $display("FAIL midreset_clear: out=%b valid=%b expected out=00 valid=0", out, valid);
    end
    step(4'b1000, 1'b1);
    vectors++;
    if (out !== 2'd3 || valid !== 1'b1) begin
      miscompares++;
      $display("FAIL midreset_resume: out=%b valid=%b expected out=11 valid=1", out, valid);
    end
  endtask

  task automatic test_back_to_back();
    for (int n = 0; n < 300; n++) begin
      logic [WIDTH-1:0] d;
      logic             r;
      logic [OUT_W-1:0] e_out;
      logic             e_valid;
      logic             e_err;
      d = WIDTH'($urandom);
      r = ($urandom_range(15) != 0);
      e_out   = r ? m_idx(d)   : '0;
      e_valid = r ? m_valid(d) : 1'b0;
      e_err   = r ? m_err(d)   : 1'b0;
      step(d, r);
      vectors++;
      if (out !== e_out || valid !== e_valid) begin
        miscompares++;
        $display("FAIL random din=%b rst_n=%b: out=%b valid=%b expected out=%b valid=%b",
                 d, r, out, valid, e_out, e_valid);
      end
`ifdef PRIORITY_DECODER_ONEHOT_ERR_EN
      vectors++;
      if (err !== e_err) begin
        miscompares++;
        $display("FAIL random_err din=%b rst_n=%b: err=%b expected %b", d, r, err, e_err);
      end
`else
      if (e_err === 1'bx) $display("model produced unknown");
`endif
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vectors     = 0;
    miscompares = 0;
    din         = '0;
    rst_n       = 1'b0;
    test_reset();
    test_onehot_walk();
    test_empty();
    test_multihot();
    test_latency();
    test_reset_midstream();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
